// File: rtl/stream_xbar.sv
// Stream crossbar: S source streams routed to M sink streams by s_dest_i.
// Each sink arbitrates round-robin per packet and holds the grant until last.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   s_data_i[S]    source beat data          s_dest_i[S]  destination index
//   s_last_i[S]    source last beat          s_valid_i[S] source valid
//   s_ready_o[S]   source beat accepted
//   m_data_o[M]    sink beat data            m_id_o[M]    granted source index
//   m_last_o[M]    sink last beat            m_valid_o[M] sink valid
//   m_ready_i[M]   sink ready
module stream_xbar #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [T_DATA_WIDTH-1:0]  s_data_i  [S_DATA_COUNT],
    input  logic [$clog2(M_DATA_COUNT)-1:0] s_dest_i [S_DATA_COUNT],
    input  logic [S_DATA_COUNT-1:0]  s_last_i,
    input  logic [S_DATA_COUNT-1:0]  s_valid_i,
    output logic [S_DATA_COUNT-1:0]  s_ready_o,
    output logic [T_DATA_WIDTH-1:0]  m_data_o  [M_DATA_COUNT],
    output logic [$clog2(S_DATA_COUNT)-1:0] m_id_o [M_DATA_COUNT],
    output logic [M_DATA_COUNT-1:0]  m_last_o,
    output logic [M_DATA_COUNT-1:0]  m_valid_o,
    input  logic [M_DATA_COUNT-1:0]  m_ready_i
);

    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Source index found i steps above pointer p, wrapping at S.
    function automatic logic [T_ID___WIDTH-1:0] rr_idx(
        input logic [T_ID___WIDTH-1:0] p,
        input int                      i
    );
        int t;
        t = (int'(p) + i) % S_DATA_COUNT;
        return T_ID___WIDTH'(t);
    endfunction

    // One-hot "granted by this sink" and "made ready by this sink" per output,
    // OR-reduced through an accumulation chain.
    logic [S_DATA_COUNT-1:0] gnt_oh  [M_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] rdy_oh  [M_DATA_COUNT];
    logic [S_DATA_COUNT-1:0] gnt_acc [M_DATA_COUNT+1];
    logic [S_DATA_COUNT-1:0] rdy_acc [M_DATA_COUNT+1];
    logic [S_DATA_COUNT-1:0] granted;
    logic [S_DATA_COUNT-1:0] discard;
    logic [S_DATA_COUNT-1:0] req     [M_DATA_COUNT];

    assign gnt_acc[0] = '0;
    assign rdy_acc[0] = '0;
    assign granted    = gnt_acc[M_DATA_COUNT];
    assign s_ready_o  = rdy_acc[M_DATA_COUNT] | discard;

    // Beats addressed past the last sink are swallowed, unless the source
    // already owns a sink (dest is ignored once granted).
    for (genvar s = 0; s < S_DATA_COUNT; s++) begin : g_src
        assign discard[s] = s_valid_i[s] && !granted[s]
                         && (int'(s_dest_i[s]) >= M_DATA_COUNT);
    end

    for (genvar x = 0; x < M_DATA_COUNT; x++) begin : g_out
        state_t                  st_q;
        logic [T_ID___WIDTH-1:0] g_q;
        logic [T_ID___WIDTH-1:0] g_d;
        logic [T_ID___WIDTH-1:0] p_q;
        logic                    hit;
        logic                    busy;
        logic                    fin;

        for (genvar s = 0; s < S_DATA_COUNT; s++) begin : g_req
            assign req[x][s] = s_valid_i[s] && !granted[s]
                            && (int'(s_dest_i[s]) == x);
        end

        assign busy = (st_q == BUSY);
        assign fin  = busy && s_valid_i[g_q] && s_last_i[g_q]
                   && m_ready_i[x];

        assign gnt_oh[x] = busy ?
            ({{(S_DATA_COUNT-1){1'b0}}, 1'b1} << g_q) : '0;
        assign rdy_oh[x] = m_ready_i[x] ? gnt_oh[x] : '0;
        assign gnt_acc[x+1] = gnt_acc[x] | gnt_oh[x];
        assign rdy_acc[x+1] = rdy_acc[x] | rdy_oh[x];

        // Round-robin search starting one above the last winner.
        always_comb begin
            hit = 1'b0;
            g_d = p_q;
            for (int i = 1; i <= S_DATA_COUNT; i++) begin
                if (!hit && req[x][rr_idx(p_q, i)]) begin
                    hit = 1'b1;
                    g_d = rr_idx(p_q, i);
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                st_q <= IDLE;
                g_q  <= '0;
                p_q  <= T_ID___WIDTH'(S_DATA_COUNT - 1);
            end else begin
                unique case (st_q)
                    IDLE: begin
                        if (hit) begin
                            st_q <= BUSY;
                            g_q  <= g_d;
                        end
                    end
                    BUSY: begin
                        if (fin) begin
                            st_q <= IDLE;
                            p_q  <= g_q;
                        end
                    end
                endcase
            end
        end

        // Data path is a pure mux once granted: no added latency per beat.
        assign m_data_o[x]  = busy ? s_data_i[g_q] : '0;
        assign m_id_o[x]    = busy ? g_q : '0;
        assign m_valid_o[x] = busy && s_valid_i[g_q];
        assign m_last_o[x]  = busy && s_valid_i[g_q] && s_last_i[g_q];
    end

endmodule

// File: doc/stream_xbar.md
STREAM_XBAR -- requirements
Module: stream_xbar

Interface
REQ-001 The block SHALL have parameter T_DATA_WIDTH, default 8: data width of every stream.
REQ-002 The block SHALL have parameter S_DATA_COUNT, default 2: number of source (input) streams, >= 2.
REQ-003 The block SHALL have parameter M_DATA_COUNT, default 3: number of sink (output) streams, >= 2.
REQ-004 The block SHALL have localparam T_ID___WIDTH = $clog2(S_DATA_COUNT) and localparam T_DEST_WIDTH = $clog2(M_DATA_COUNT).
REQ-005 The block SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port s_data_i  input  T_DATA_WIDTH x S_DATA_COUNT (unpacked)  source beat data.
REQ-008 The block SHALL have port s_dest_i  input  T_DEST_WIDTH x S_DATA_COUNT (unpacked)  destination output index.
REQ-009 The block SHALL have port s_last_i  input  S_DATA_COUNT  last beat of packet.
REQ-010 The block SHALL have port s_valid_i  input  S_DATA_COUNT  source beat valid.
REQ-011 The block SHALL have port s_ready_o  output  S_DATA_COUNT  source beat accepted.
REQ-012 The block SHALL have port m_data_o  output  T_DATA_WIDTH x M_DATA_COUNT (unpacked)  output beat data.
REQ-013 The block SHALL have port m_id_o  output  T_ID___WIDTH x M_DATA_COUNT (unpacked)  index of source currently granted.
REQ-014 The block SHALL have ports m_last_o, m_valid_o (outputs) and m_ready_i (input), each M_DATA_COUNT wide, with AXI-Stream meaning.

Function
REQ-015 A beat SHALL transfer on a stream only in a cycle where valid and ready are both 1.
REQ-016 Each output x SHALL run an independent two-state FSM: IDLE, BUSY, plus a granted-source register g[x] and a round-robin pointer p[x].
REQ-017 Source s SHALL request output x when s_valid_i[s]=1, s_dest_i[s]=x, and s is not currently granted by any output in BUSY.
REQ-018 In IDLE with at least one request, output x SHALL grant the requesting source first found searching upward (with wrap) from p[x]+1, load g[x], and enter BUSY next cycle.
REQ-019 In IDLE, m_valid_o[x]=0, m_last_o[x]=0, m_data_o[x]=0, m_id_o[x]=0, and no source is made ready by output x.
REQ-020 In BUSY, output x SHALL combinationally drive m_data_o[x]=s_data_i[g], m_last_o[x]=s_last_i[g]&s_valid_i[g], m_valid_o[x]=s_valid_i[g], m_id_o[x]=g, s_ready_o[g]=m_ready_i[x].
REQ-021 Latency: first beat of a packet SHALL appear on m_valid_o one cycle after it is first presented and requested (arbitration cycle); subsequent beats SHALL pass with zero latency.
REQ-022 s_dest_i SHALL be sampled only at grant; changes during BUSY SHALL NOT redirect the packet.
REQ-023 On a transfer with m_last_o[x]=1, output x SHALL return to IDLE and set p[x]=g[x]; a new grant SHALL need one further IDLE cycle (one bubble between packets).
REQ-024 A source with s_dest_i >= M_DATA_COUNT and s_valid_i=1, not granted anywhere, SHALL get s_ready_o=1 and its beat SHALL be discarded.
REQ-025 Different outputs granting different sources SHALL transfer concurrently without interaction.
REQ-026 m_valid_o[x] SHALL drop with s_valid_i[g] mid-packet without losing the grant; the packet SHALL hold the output until its last beat.
REQ-027 s_ready_o[s] SHALL be 0 whenever s is neither granted nor discarded per REQ-024.

Reset
REQ-028 While rst_i=1, all FSMs SHALL be IDLE, g[x]=0, p[x]=S_DATA_COUNT-1 (source 0 highest priority), so all m_valid_o, m_last_o, s_ready_o read 0 (except REQ-024 discard).
REQ-029 Reset asserted mid-packet SHALL abort the packet immediately; the remainder is not forwarded and no state survives.

Verification
REQ-030 After reset, s0 valid dest=1 data=0xA5 last=1, m_ready_i=all 1 -> cycle 1 nothing, cycle 2 m_valid_o[1]=1, m_data_o[1]=0xA5, m_id_o[1]=0, m_last_o[1]=1, s_ready_o[0]=1.
REQ-031 s0 and s1 both dest=0, 1-beat packets held continuously -> grants alternate s0,s1,s0 with one idle cycle between, m_id_o[0]=0,1,0.
REQ-032 s0 3-beat packet to out 2, s0 changes s_dest_i to 0 after beat 1 -> all 3 beats on m_data_o[2]; out 0 never valid until packet ends.
REQ-033 s0 dest=0, s1 dest=2 simultaneously, m_ready_i[2]=0 for 4 cycles -> out 0 completes, s_ready_o[1]=0 and m_data_o[2] stable for 4 cycles.
REQ-034 M_DATA_COUNT=3, s1 dest=3 valid -> s_ready_o[1]=1, no m_valid_o asserted.
REQ-035 rst_i pulsed during beat 2 of a 4-beat packet -> m_valid_o=0 asynchronously; next grant favours source 0.
